// File: rtl/lane_logic_pipe_pkg.sv
// lane_logic_pipe_pkg: mode enumeration and bitwise lane operator
// shared by lane_logic_pipe and lane_logic_pipe_stage.
package lane_logic_pipe_pkg;

  typedef enum logic [1:0] {
    AND_XOR = 2'd0,
    OR_XOR  = 2'd1,
    XOR3    = 2'd2,
    PASS    = 2'd3
  } mode_e;

  localparam int CNT_W = 32;

  // The lane operator is purely bitwise, so one bit position of a
  // lane fully describes it; callers sweep it across every lane bit.
  function automatic logic lane_op(
    input logic  a,
    input logic  b,
    input logic  c,
    input mode_e m
  );
    logic y;
    logic r;
    y = b ^ c;
    r = a;
    unique case (m)
      AND_XOR: r = a & y;
      OR_XOR:  r = a | y;
      XOR3:    r = a ^ y;
      PASS:    r = a;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lane_logic_pipe_stage.sv
// lane_logic_pipe_stage: one elastic slot holding valid, operands, mode.
// Ports: up_* beat offered from upstream, down_ready from downstream,
// valid/data/mode slot contents, ready = slot can take a beat this cycle.
module lane_logic_pipe_stage
  import lane_logic_pipe_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [3*DW-1:0] up_data,
  input  mode_e         up_mode,
  input  logic          down_ready,
  output logic          valid,
  output logic [3*DW-1:0] data,
  output mode_e         mode,
  output logic          ready
);

  logic advance;
  logic load;

  assign advance = valid & down_ready;
  assign ready   = ~valid | advance;
  assign load    = up_valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      mode  <= AND_XOR;
    end else if (load) begin
      valid <= 1'b1;
      data  <= up_data;
      mode  <= up_mode;
    end else if (advance) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lane_logic_pipe.sv
// lane_logic_pipe: DEPTH-stage elastic pipe of per-lane a op (b^c).
// Ports: clk, rst (sync, high), in_valid/in_ready/in_mode/in_a/in_b/in_c,
// out_valid/out_ready/out_x; beat_count/stall_count with
// LANE_LOGIC_PIPE_STATS_EN defined.
module lane_logic_pipe
  import lane_logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [LANES*WIDTH-1:0] in_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_x
`ifdef LANE_LOGIC_PIPE_STATS_EN
  ,
  output logic [31:0]            beat_count,
  output logic [31:0]            stall_count
`endif
);

  localparam int DW = LANES * WIDTH;

  if (DEPTH < 1 || WIDTH < 1 || LANES < 1) begin : g_bad_cfg
    $error("lane_logic_pipe: DEPTH, WIDTH and LANES must all be >= 1");
  end

  (* public_flat_rw *)
  logic [DEPTH-1:0] stage_valid;
  logic [3*DW-1:0]  stage_data [DEPTH];
  mode_e            stage_mode [DEPTH];

  // Ready ripples from the sink back to the head; each slot keeps its
  // own ready wire so the chain is a set of scalars, not one vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic            up_valid;
    logic [3*DW-1:0] up_data;
    mode_e           up_mode;
    logic            down_ready;
    logic            rdy;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = {in_c, in_b, in_a};
      assign up_mode  = mode_e'(in_mode);
    end else begin : g_body
      assign up_valid = stage_valid[i-1];
      assign up_data  = stage_data[i-1];
      assign up_mode  = stage_mode[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_link
      assign down_ready = g_stage[i+1].rdy;
    end

    lane_logic_pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .up_valid  (up_valid),
      .up_data   (up_data),
      .up_mode   (up_mode),
      .down_ready(down_ready),
      .valid     (stage_valid[i]),
      .data      (stage_data[i]),
      .mode      (stage_mode[i]),
      .ready     (rdy)
    );
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = stage_valid[DEPTH-1];

  // Operands travel raw with their mode; the result is formed from
  // the tail slot so it stays stable for as long as the slot holds.
  always_comb begin
    out_x = '0;
    if (out_valid) begin
      for (int j = 0; j < DW; j++) begin
        out_x[j] = lane_op(
          stage_data[DEPTH-1][j],
          stage_data[DEPTH-1][DW+j],
          stage_data[DEPTH-1][2*DW+j],
          stage_mode[DEPTH-1]
        );
      end
    end
  end

`ifdef LANE_LOGIC_PIPE_STATS_EN
  (* public_flat_rw *)
  logic [CNT_W-1:0] beat_q;
  (* public_flat_rw *)
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid & out_ready) begin
        beat_q <= sat_inc(beat_q);
      end
      if (out_valid & ~out_ready) begin
        stall_q <= sat_inc(stall_q);
      end
    end
  end

  assign beat_count  = beat_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_lane_logic_pipe.sv
// tb_lane_logic_pipe: scoreboard bench for lane_logic_pipe, a DEPTH=3
// LANES=2 instance for directed cases and DEPTH=1 LANES=4 for random.
module tb_lane_logic_pipe;

  localparam int W  = 8;
  localparam int LA = 2;
  localparam int DA = 3;
  localparam int LB = 4;
  localparam int DB = 1;
  localparam int XA = LA * W;
  localparam int XB = LB * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic          a_rst, a_iv, a_ir, a_ov, a_or;
  logic [1:0]    a_m;
  logic [XA-1:0] a_a, a_b, a_c, a_x;
  logic          b_rst, b_iv, b_ir, b_ov, b_or;
  logic [1:0]    b_m;
  logic [XB-1:0] b_a, b_b, b_c, b_x;
`ifdef LANE_LOGIC_PIPE_STATS_EN
  logic [31:0]   a_bc, a_sc, b_bc, b_sc;
`endif

  lane_logic_pipe #(.WIDTH(W), .LANES(LA), .DEPTH(DA)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .in_valid(a_iv), .in_ready(a_ir), .in_mode(a_m),
    .in_a(a_a), .in_b(a_b), .in_c(a_c),
    .out_valid(a_ov), .out_ready(a_or), .out_x(a_x)
`ifdef LANE_LOGIC_PIPE_STATS_EN
    , .beat_count(a_bc), .stall_count(a_sc)
`endif
  );

  lane_logic_pipe #(.WIDTH(W), .LANES(LB), .DEPTH(DB)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_mode(b_m),
    .in_a(b_a), .in_b(b_b), .in_c(b_c),
    .out_valid(b_ov), .out_ready(b_or), .out_x(b_x)
`ifdef LANE_LOGIC_PIPE_STATS_EN
    , .beat_count(b_bc), .stall_count(b_sc)
`endif
  );

  typedef struct {
    logic [63:0] x;
    int          acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  bit   lat_chk = 1'b0;
  int   b_hs = 0;
  int   b_acc = 0;

  // Whole-bus reference: the operation is bitwise, so lanes need no split.
  function automatic logic [63:0] model(
    input logic [1:0] m,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] c
  );
    case (m)
      2'd0:    return a & (b ^ c);
      2'd1:    return a | (b ^ c);
      2'd2:    return a ^ b ^ c;
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Stimulus side of the scoreboard: every accepted beat queues its answer.
  always @(negedge clk) begin
    if (!a_rst && a_iv && a_ir)
      qa.push_back('{model(a_m, 64'(a_a), 64'(a_b), 64'(a_c)), cyc});
    if (!b_rst && b_iv && b_ir) begin
      qb.push_back('{model(b_m, 64'(b_a), 64'(b_b), 64'(b_c)), cyc});
      b_acc++;
    end
  end

  always @(negedge clk) begin
    if (a_rst) begin
      qa.delete();
    end else if (a_ov) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected actual=%0h required=no_output", a_x);
      end else begin
        check("a_out_x", 64'(a_x), qa[0].x);
        if (a_or) begin
          if (lat_chk) check("a_latency", 64'(cyc - qa[0].acc), 64'(DA));
          void'(qa.pop_front());
        end
      end
    end else begin
      check("a_idle_zero", 64'(a_x), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (b_rst) begin
      qb.delete();
    end else if (b_ov) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected actual=%0h required=no_output", b_x);
      end else begin
        check("b_out_x", 64'(b_x), qb[0].x);
        if (b_or) begin
          void'(qb.pop_front());
          b_hs++;
        end
      end
    end else begin
      check("b_idle_zero", 64'(b_x), 64'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit seen;
    a_rst = 1'b1; a_iv = 1'b0; a_or = 1'b1; a_m = 2'd0;
    a_a = '0; a_b = '0; a_c = '0;
    b_rst = 1'b1; b_iv = 1'b0; b_or = 1'b1; b_m = 2'd0;
    b_a = '0; b_b = '0; b_c = '0;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(a_ov), 64'd0);
    check("rst_in_ready", 64'(a_ir), 64'd1);
`ifdef LANE_LOGIC_PIPE_STATS_EN
    check("rst_beat_count", 64'(a_bc), 64'd0);
    check("rst_stall_count", 64'(a_sc), 64'd0);
`endif

    // Single beat, fixed latency.
    lat_chk = 1'b1;
    @(posedge clk); #1;
    a_iv = 1'b1; a_m = 2'd0;
    a_a = {LA{8'hF0}}; a_b = {LA{8'hAA}}; a_c = {LA{8'h55}};
    @(negedge clk);
    t0 = cyc;
    check("t1_in_ready", 64'(a_ir), 64'd1);
    @(posedge clk); #1 a_iv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (a_ov) seen = 1'b1;
    end
    check("t1_latency", 64'(cyc - t0), 64'(DA));
    check("t1_x", 64'(a_x), 64'hF0F0);

    // Ten back-to-back beats cycling all modes.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      a_iv = 1'b1; a_m = 2'(k % 4);
      a_a = XA'($urandom); a_b = XA'($urandom); a_c = XA'($urandom);
      @(negedge clk);
      check("t2_in_ready", 64'(a_ir), 64'd1);
    end
    @(posedge clk); #1 a_iv = 1'b0;
    repeat (6) @(negedge clk);
    check("t2_drained", 64'(qa.size()), 64'd0);
    lat_chk = 1'b0;

    // Sink stalled from an empty pipe: DEPTH beats fit, then backpressure.
    @(posedge clk); #1 a_rst = 1'b1;
    @(posedge clk); #1 a_rst = 1'b0; a_or = 1'b0;
    for (int k = 0; k < DA + 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      a_iv = 1'b1; a_m = 2'($urandom_range(0, 3));
      a_a = XA'($urandom); a_b = XA'($urandom); a_c = XA'($urandom);
      @(negedge clk);
      check("t3_in_ready", 64'(a_ir), 64'(k < DA));
    end
    @(posedge clk); #1 a_or = 1'b1; a_iv = 1'b0;
    @(negedge clk);
`ifdef LANE_LOGIC_PIPE_STATS_EN
    check("t3_stall_count", 64'(a_sc), 64'd6);
    check("t3_beat_count", 64'(a_bc), 64'd0);
`endif
    repeat (6) @(negedge clk);
    check("t3_drained", 64'(qa.size()), 64'd0);

    // Reset with two beats in flight.
    @(posedge clk); #1;
    a_iv = 1'b1; a_m = 2'd2;
    a_a = XA'($urandom); a_b = XA'($urandom); a_c = XA'($urandom);
    @(posedge clk); #1;
    a_a = XA'($urandom); a_b = XA'($urandom); a_c = XA'($urandom);
    @(posedge clk); #1 a_iv = 1'b0; a_rst = 1'b1;
    @(posedge clk); #1 a_rst = 1'b0;
    @(negedge clk);
    check("t4_out_valid", 64'(a_ov), 64'd0);
    check("t4_in_ready", 64'(a_ir), 64'd1);
`ifdef LANE_LOGIC_PIPE_STATS_EN
    check("t4_beat_count", 64'(a_bc), 64'd0);
    check("t4_stall_count", 64'(a_sc), 64'd0);
`endif
    repeat (6) @(negedge clk);
    check("t4_no_stale", 64'(qa.size()), 64'd0);

    // Random valid/ready on the single-stage, four-lane instance.
    @(posedge clk); #1 b_rst = 1'b1;
    @(posedge clk); #1 b_rst = 1'b0;
    b_hs = 0;
    b_acc = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      b_iv = ($urandom_range(0, 9) < 6);
      b_or = ($urandom_range(0, 9) < 7);
      b_m = 2'($urandom_range(0, 3));
      b_a = XB'($urandom); b_b = XB'($urandom); b_c = XB'($urandom);
    end
    @(posedge clk); #1 b_iv = 1'b0; b_or = 1'b1;
    repeat (4) @(negedge clk);
    check("b_drained", 64'(qb.size()), 64'd0);
    check("b_all_delivered", 64'(b_hs), 64'(b_acc));
`ifdef LANE_LOGIC_PIPE_STATS_EN
    check("b_beat_count", 64'(b_bc), 64'(b_hs));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
